// File: rtl/sr_latch_driver.sv
// Initiator for a gated SR storage cell: sequences setup/strobe/hold/release on s/r/c,
// then reads q/qbar back through synchronizers. Optional retry: SR_LATCH_DRIVER_RETRY_EN.
module sr_latch_driver #(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic req_op,
    input  logic wr_bit,
    output logic ready,
    output logic done,
    output logic rd_bit,
    output logic err,
`ifdef SR_LATCH_DRIVER_RETRY_EN
    output logic retried,
`endif
    output logic latch_s,
    output logic latch_r,
    output logic latch_c,
    input  logic latch_q,
    input  logic latch_qbar
);

    localparam int unsigned SETTLE_LEN = SETTLE_CYCLES + 2;
    localparam int unsigned MAX_AB     = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int unsigned MAX_CD     = (HOLD_CYCLES > SETTLE_LEN) ? HOLD_CYCLES : SETTLE_LEN;
    localparam int unsigned MAX_LEN    = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW         = $clog2(MAX_LEN) + 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] STROBE = 3'd2;
    localparam logic [2:0] HOLD   = 3'd3;
    localparam logic [2:0] SETTLE = 3'd4;
    localparam logic [2:0] CHECK  = 3'd5;

    logic [2:0]    state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          op_wr_r, bit_r;
    logic          q_meta, q_sync, qb_meta, qb_sync;
    logic          retry_pend;
    logic          retry_now_c, finish_c, chk_err_c, drive_c, wbit_c, last_c;
`ifdef SR_LATCH_DRIVER_RETRY_EN
    logic          retried_r;
`endif

    // Count loaded on phase entry; phase lasts load+1 cycles.
    function automatic logic [CW-1:0] phase_load(input logic [2:0] st);
        case (st)
            SETUP:   phase_load = CW'(SETUP_CYCLES - 1);
            STROBE:  phase_load = CW'(STROBE_CYCLES - 1);
            HOLD:    phase_load = CW'(HOLD_CYCLES - 1);
            SETTLE:  phase_load = CW'(SETTLE_LEN - 1);
            default: phase_load = '0;
        endcase
    endfunction

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        last_c      = (cnt == '0);
        chk_err_c   = (q_sync == qb_sync) || (op_wr_r && (q_sync != bit_r));
`ifdef SR_LATCH_DRIVER_RETRY_EN
        // Only a clean wrong value retries; q==qbar is reported immediately.
        retry_now_c = op_wr_r && !retried_r && (q_sync != bit_r) && (q_sync != qb_sync);
`else
        retry_now_c = 1'b0;
`endif
        finish_c    = (state == SETTLE) && last_c && !retry_now_c;
        wbit_c      = (state == IDLE) ? wr_bit : bit_r;

        case (state)
            IDLE:    if (req) state_next = req_op ? SETTLE : SETUP;
            SETUP:   if (last_c) state_next = STROBE;
            STROBE:  if (last_c) state_next = HOLD;
            HOLD:    if (last_c) state_next = SETTLE;
            SETTLE:  if (last_c) state_next = CHECK;
            CHECK:   state_next = retry_pend ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase

        if (state_next != state) cnt_next = phase_load(state_next);
        else if (!last_c)        cnt_next = cnt - CW'(1);

        drive_c = (state_next == SETUP) || (state_next == STROBE) || (state_next == HOLD);
    end

    // State, counter, capture and synchronizers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op_wr_r    <= 1'b0;
            bit_r      <= 1'b0;
            retry_pend <= 1'b0;
            q_meta     <= 1'b0;
            q_sync     <= 1'b0;
            qb_meta    <= 1'b0;
            qb_sync    <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            q_meta     <= latch_q;
            q_sync     <= q_meta;
            qb_meta    <= latch_qbar;
            qb_sync    <= qb_meta;
            retry_pend <= (state == SETTLE) && last_c && retry_now_c;
            if (state == IDLE && req) begin
                op_wr_r <= ~req_op;
                bit_r   <= wr_bit;
            end
        end
    end

`ifdef SR_LATCH_DRIVER_RETRY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            retried_r <= 1'b0;
            retried   <= 1'b0;
        end else begin
            if (state == IDLE && req)               retried_r <= 1'b0;
            else if (state == CHECK && retry_pend)  retried_r <= 1'b1;
            retried <= finish_c && retried_r;
        end
    end
`endif

    // Registered outputs, derived from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready   <= 1'b1;
            done    <= 1'b0;
            rd_bit  <= 1'b0;
            err     <= 1'b0;
            latch_s <= 1'b0;
            latch_r <= 1'b0;
            latch_c <= 1'b0;
        end else begin
            ready   <= (state_next == IDLE);
            done    <= finish_c;
            latch_s <= drive_c & wbit_c;
            latch_r <= drive_c & ~wbit_c;
            latch_c <= (state_next == STROBE);
            if (finish_c) begin
                rd_bit <= q_sync;
                err    <= chk_err_c;
            end
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Randomized self-checking bench for sr_latch_driver with a behavioural latch/driver model.
// Honours SR_LATCH_DRIVER_RETRY_EN when compiled with it.
module tb_sr_latch_driver;

    localparam int SETUP_N = 1, STROBE_N = 2, HOLD_N = 1, SETTLE_N = 2;
    localparam int WR_LAT  = SETUP_N + STROBE_N + HOLD_N + SETTLE_N + 3;
    localparam int RD_LAT  = SETTLE_N + 3;

    logic clk = 1'b0;
    logic reset, req, req_op, wr_bit;
    logic ready, done, rd_bit, err, latch_s, latch_r, latch_c, latch_q, latch_qbar;
`ifdef SR_LATCH_DRIVER_RETRY_EN
    logic retried;
`endif

    always #5 clk = ~clk;

    sr_latch_driver #(
        .SETUP_CYCLES(SETUP_N), .STROBE_CYCLES(STROBE_N),
        .HOLD_CYCLES(HOLD_N), .SETTLE_CYCLES(SETTLE_N)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_op(req_op), .wr_bit(wr_bit),
        .ready(ready), .done(done), .rd_bit(rd_bit), .err(err),
`ifdef SR_LATCH_DRIVER_RETRY_EN
        .retried(retried),
`endif
        .latch_s(latch_s), .latch_r(latch_r), .latch_c(latch_c),
        .latch_q(latch_q), .latch_qbar(latch_qbar)
    );

    // Latch cell model: mode 0 healthy, 1 stuck q=0/qbar=1, 2 illegal q=qbar=1.
    logic mq, set_req, set_val;
    int   mode;
    always @(negedge clk) begin
        if (set_req)                 mq <= set_val;
        else if (latch_c && latch_s) mq <= 1'b1;
        else if (latch_c && latch_r) mq <= 1'b0;
    end
    assign latch_q    = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : mq;
    assign latch_qbar = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b1 : ~mq;

    int n_tests = 0, n_fail = 0, done_cnt = 0, sr_viol = 0;
    logic ref_q;

    always @(posedge clk) if (done) done_cnt++;
    always @(negedge clk) if (latch_s && latch_r) sr_viol++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic preset_q(input logic v);
        @(posedge clk); set_req = 1'b1; set_val = v;
        @(posedge clk); set_req = 1'b0;
    endtask

    task automatic set_mode(input int m);
        @(negedge clk); mode = m;
        repeat (4) @(negedge clk);
    endtask

    // Expected drive window for cycle k after acceptance (second pass shifted after a retry).
    function automatic logic [63:0] exp_trace(input int lat, input logic rd, input logic rt, input logic want_c);
        logic [63:0] v = '0;
        for (int k = 1; k <= lat && k < 64; k++) begin
            int pos = (rt && k > WR_LAT) ? k - WR_LAT : k;
            if (!rd) begin
                if (want_c) v[k] = (pos > SETUP_N) && (pos <= SETUP_N + STROBE_N);
                else        v[k] = (pos >= 1) && (pos <= SETUP_N + STROBE_N + HOLD_N);
            end
        end
        return v;
    endfunction

    task automatic do_txn(input logic op, input logic b, input int hold);
        int lat = 0, d0, exp_lat;
        logic got_rd = 1'b0, got_err = 1'b0, got_rt = 1'b0, rdy1 = 1'b1;
        logic exp_rd, exp_err, exp_rt;
        logic [63:0] s_tr = '0, r_tr = '0, c_tr = '0;

        exp_rt = 1'b0;
        if (mode == 2)      begin exp_rd = 1'b1;  exp_err = 1'b1; end
        else if (mode == 1) begin exp_rd = 1'b0;  exp_err = !op && b; end
        else                begin exp_rd = op ? ref_q : b; exp_err = 1'b0; end
`ifdef SR_LATCH_DRIVER_RETRY_EN
        exp_rt = (mode == 1) && !op && b;
`endif
        exp_lat = op ? RD_LAT : (exp_rt ? 2 * WR_LAT : WR_LAT);
        if (!op) ref_q = b;

        for (int w = 0; w < 50 && !ready; w++) @(negedge clk);
        @(negedge clk);
        req = 1'b1; req_op = op; wr_bit = b;
        @(posedge clk);
        d0 = done_cnt;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k >= hold) req = 1'b0;
            req_op = 1'($urandom); wr_bit = 1'($urandom);
            if (k == 1) rdy1 = ready;
            s_tr[k] = latch_s; r_tr[k] = latch_r; c_tr[k] = latch_c;
            if (done) begin
                lat = k; got_rd = rd_bit; got_err = err;
`ifdef SR_LATCH_DRIVER_RETRY_EN
                got_rt = retried;
`endif
                break;
            end
        end
        req = 1'b0;
        repeat (2) @(negedge clk);

        check("latency", 64'(lat), 64'(exp_lat));
        check("rd_bit", 64'(got_rd), 64'(exp_rd));
        check("err", 64'(got_err), 64'(exp_err));
        check("ready_drop", 64'(rdy1), 64'(0));
        check("one_done", 64'(done_cnt - d0), 64'(1));
        check("s_trace", s_tr, exp_trace(exp_lat, op, exp_rt, 1'b0) & {64{b}});
        check("r_trace", r_tr, exp_trace(exp_lat, op, exp_rt, 1'b0) & {64{~b}});
        check("c_trace", c_tr, exp_trace(exp_lat, op, exp_rt, 1'b1));
`ifdef SR_LATCH_DRIVER_RETRY_EN
        check("retried", 64'(got_rt), 64'(exp_rt));
`else
        check("retried_absent", 64'(got_rt), 64'(0));
`endif
    endtask

    initial begin
        int d0;
        reset = 1'b1; req = 1'b0; req_op = 1'b0; wr_bit = 1'b0;
        set_req = 1'b0; set_val = 1'b0; mode = 0; ref_q = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_done", 64'(done), 64'(0));
        check("rst_outs", 64'({rd_bit, err, latch_s, latch_r, latch_c}), 64'(0));
        reset = 1'b0;
        preset_q(1'b0);
        repeat (3) @(negedge clk);

        do_txn(1'b0, 1'b1, 1);
        do_txn(1'b0, 1'b0, 3);

        // Abandon a write 1 while the strobe is high.
        @(negedge clk);
        req = 1'b1; req_op = 1'b0; wr_bit = 1'b1;
        @(posedge clk);
        d0 = done_cnt;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        check("mid_strobe_c", 64'(latch_c), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_drive", 64'({latch_s, latch_r, latch_c}), 64'(0));
        check("rst_mid_ready", 64'(ready), 64'(1));
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("rst_mid_nodone", 64'(done_cnt - d0), 64'(0));
        ref_q = 1'b1;

        do_txn(1'b1, 1'b0, 4);
        set_mode(1);
        do_txn(1'b0, 1'b1, 2);
        do_txn(1'b0, 1'b0, 1);
        set_mode(2);
        do_txn(1'b1, 1'b1, 4);
        do_txn(1'b0, 1'b0, 1);
        set_mode(0);

        for (int i = 0; i < 30; i++) begin
            int m = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            if (m != mode) set_mode(m);
            do_txn(1'($urandom), 1'($urandom), int'($urandom_range(1, 4)));
        end

        check("sr_never_both", 64'(sr_viol), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
